controlador_ram: RTL
====================

// Module: controlador_ram
// PURPOSE
//   Initiator-side controller for the small word RAM port (enable / write_enable / addr / data).
//   Accepts host read, write and clear commands over a valid/ready handshake.
//   Sequences the RAM control lines cycle by cycle and returns read data over a valid/ready response channel.
//   Sits between the datapath (host) and the RAM array; it is the only driver of the RAM port.
// PARAMETERS
//   DATA_W  8  word width; matches RAM data width
//   ADDR_W  1  address width; RAM depth = 2**ADDR_W (default 2 words)
//   RD_LAT  1  cycles ram_enable is held for a read before ram_dados_in is captured (>=1)
// PORTS
//   clk               in   1       single clock, rising edge
//   rst_n             in   1       asynchronous reset, active-low
//   req_valido        in   1       host command valid
//   req_pronto        out  1       controller ready to accept a command
//   req_escrita       in   1       1 = write, 0 = read (ignored when req_limpar=1)
//   req_limpar        in   1       1 = clear: write req_dados to every address
//   req_endereco      in   ADDR_W  command address
//   req_dados         in   DATA_W  write data / clear fill value
//   resp_valido       out  1       read data valid
//   resp_pronto       in   1       host accepts read data
//   resp_dados        out  DATA_W  read data
//   ram_enable        out  1       to RAM enable
//   ram_write_enable  out  1       to RAM write_enable
//   ram_addr          out  ADDR_W  to RAM addr
//   ram_dados_out     out  DATA_W  to RAM dados_in
//   ram_dados_in      in   DATA_W  from RAM dados_out
//   ocupado           out  1       1 whenever state != OCIOSO
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: req_pronto=0, ocupado=0, resp_valido=0, resp_dados=0, ram_enable=0, ram_write_enable=0, ram_addr=0, ram_dados_out=0.
//   - req_pronto rises in the first clk edge after rst_n deasserts.
//   - FSM states: OCIOSO, ESCRITA, LEITURA, RESPOSTA, LIMPEZA. req_pronto=1 only in OCIOSO.
//   - Command acceptance:
//     - A command is accepted on an edge where req_valido & req_pronto.
//     - All req_* fields are sampled only at acceptance; later changes are ignored.
//     - Priority: req_limpar > req_escrita > read.
//   - Write (accepted in cycle N):
//     - ESCRITA in N+1: ram_enable=1, ram_write_enable=1, ram_addr/ram_dados_out = sampled values, for exactly 1 cycle.
//     - OCIOSO in N+2: req_pronto=1, ram_enable=0.
//   - Read:
//     - LEITURA for N+1..N+RD_LAT: ram_enable=1, ram_write_enable=0, ram_addr held; counter counts RD_LAT cycles.
//     - ram_dados_in is captured into resp_dados on the last LEITURA edge.
//     - RESPOSTA from N+RD_LAT+1: resp_valido=1 and resp_dados stable until an edge with resp_pronto=1.
//     - That edge clears resp_valido and returns to OCIOSO.
//     - resp_pronto is ignored while resp_valido=0.
//   - Clear:
//     - LIMPEZA for N+1..N+2**ADDR_W: ram_enable=1, ram_write_enable=1, ram_dados_out=fill.
//     - ram_addr steps 0,1,...,2**ADDR_W-1, one per cycle; req_endereco is ignored.
//     - After the last address the counter wraps to 0 and the FSM goes to OCIOSO.
//   - ram_write_enable=0 and ram_enable=0 in OCIOSO and RESPOSTA; ram_dados_out holds its last value.
//   - Back-to-back commands: no new command is accepted in the cycle the FSM returns to OCIOSO.
//     - Minimum spacing is one OCIOSO cycle: write-to-write every 2 cycles.
//   - Reset mid-operation: rst_n low immediately forces all outputs to their reset values.
//     - The in-flight command is dropped; no partial response is issued after reset.
//     - A partially completed clear leaves RAM contents undefined.
//   - Width rules:
//     - Address counter is ADDR_W bits and wraps modulo 2**ADDR_W.
//     - Latency counter is clog2(RD_LAT+1) bits.
// TESTING
//   1. Reset: rst_n=0 mid-clock -> all outputs 0 asynchronously; first edge after release -> req_pronto=1, ocupado=0.
//   2. Write 8'hA5 to addr 1 (accepted cycle N) -> cycle N+1: ram_enable=1, ram_write_enable=1, ram_addr=1, ram_dados_out=A5; N+2: req_pronto=1.
//   3. Read addr 1 with RD_LAT=1 and resp_pronto held 0 for 3 cycles -> resp_valido=1 from N+2, resp_dados=A5 stable; cleared the cycle after resp_pronto=1.
//   4. Clear with fill 8'h3C -> ram_addr 0 then 1 with write_enable=1; subsequent reads of addr 0 and 1 return 3C.
//   5. Simultaneous req_limpar=1 and req_escrita=1 -> clear sequence executes; no single-address write.
//   6. rst_n pulsed low during LEITURA -> ram_enable=0 immediately; resp_valido never rises; next read completes normally.

Source files
------------

// File: rtl/controlador_ram.sv
// Initiator-side controller for a small word RAM port: sequences read, write and
// clear commands taken over a valid/ready request channel and returns read data.
module controlador_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 1,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valido,
   output logic              req_pronto,
   input  logic              req_escrita,
   input  logic              req_limpar,
   input  logic [ADDR_W-1:0] req_endereco,
   input  logic [DATA_W-1:0] req_dados,
   output logic              resp_valido,
   input  logic              resp_pronto,
   output logic [DATA_W-1:0] resp_dados,
   output logic              ram_enable,
   output logic              ram_write_enable,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dados_out,
   input  logic [DATA_W-1:0] ram_dados_in,
   output logic              ocupado
);

   localparam logic [2:0] OCIOSO   = 3'd0;
   localparam logic [2:0] ESCRITA  = 3'd1;
   localparam logic [2:0] LEITURA  = 3'd2;
   localparam logic [2:0] RESPOSTA = 3'd3;
   localparam logic [2:0] LIMPEZA  = 3'd4;

   localparam int                CNT_W     = $clog2(RD_LAT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   logic [2:0]       estado;
   logic [CNT_W-1:0] cnt_lat;
   logic             aceita;

   assign aceita = req_valido & req_pronto;

   // Every output is a register; the clear walk reuses ram_addr as its address counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado           <= OCIOSO;
         cnt_lat          <= '0;
         req_pronto       <= 1'b0;
         ocupado          <= 1'b0;
         resp_valido      <= 1'b0;
         resp_dados       <= '0;
         ram_enable       <= 1'b0;
         ram_write_enable <= 1'b0;
         ram_addr         <= '0;
         ram_dados_out    <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (aceita) begin
                  req_pronto <= 1'b0;
                  ocupado    <= 1'b1;
                  ram_enable <= 1'b1;
                  if (req_limpar) begin
                     estado           <= LIMPEZA;
                     ram_write_enable <= 1'b1;
                     ram_addr         <= '0;
                     ram_dados_out    <= req_dados;
                  end else if (req_escrita) begin
                     estado           <= ESCRITA;
                     ram_write_enable <= 1'b1;
                     ram_addr         <= req_endereco;
                     ram_dados_out    <= req_dados;
                  end else begin
                     estado           <= LEITURA;
                     ram_write_enable <= 1'b0;
                     ram_addr         <= req_endereco;
                     cnt_lat          <= '0;
                  end
               end else begin
                  req_pronto <= 1'b1;
                  ocupado    <= 1'b0;
               end
            end
            ESCRITA: begin
               estado           <= OCIOSO;
               ram_enable       <= 1'b0;
               ram_write_enable <= 1'b0;
               req_pronto       <= 1'b1;
               ocupado          <= 1'b0;
            end
            LEITURA: begin
               // RAM data is taken on the last of the RD_LAT enabled cycles.
               if (cnt_lat == CNT_LAST) begin
                  estado      <= RESPOSTA;
                  cnt_lat     <= '0;
                  ram_enable  <= 1'b0;
                  resp_dados  <= ram_dados_in;
                  resp_valido <= 1'b1;
               end else begin
                  cnt_lat <= cnt_lat + 1'b1;
               end
            end
            RESPOSTA: begin
               if (resp_pronto) begin
                  estado      <= OCIOSO;
                  resp_valido <= 1'b0;
                  req_pronto  <= 1'b1;
                  ocupado     <= 1'b0;
               end
            end
            LIMPEZA: begin
               if (ram_addr == ADDR_LAST) begin
                  estado           <= OCIOSO;
                  ram_addr         <= '0;
                  ram_enable       <= 1'b0;
                  ram_write_enable <= 1'b0;
                  req_pronto       <= 1'b1;
                  ocupado          <= 1'b0;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
               end
            end
            default: begin
               estado           <= OCIOSO;
               ram_enable       <= 1'b0;
               ram_write_enable <= 1'b0;
               resp_valido      <= 1'b0;
               req_pronto       <= 1'b0;
               ocupado          <= 1'b0;
            end
         endcase
      end
   end

endmodule
